// File: rtl/ym_bus_pkg.sv
// ym_bus_pkg: types and constants shared by the YM2151 bus master and its
// bus-phase engine.
//   state_e  : command sequencer states
//   phase_e  : phases of one timed bus cycle
//   BUSY_BIT : status bit polled before every register write
package ym_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POLL,
        CHECK,
        ADDR,
        DATA
    } state_e;

    typedef enum logic [1:0] {
        SETUP,
        STRB,
        HOLD,
        GAP
    } phase_e;

    localparam int unsigned BUSY_BIT = 7;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ym_bus_phase.sv
// ym_bus_phase: runs one timed YM2151 bus cycle (read or write).
//   A cycle is SETUP_CYC + STRB_CYC + HOLD_CYC clocks with cs_n low, followed
//   by one GAP clock with cs_n high and the bus released.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             begin a cycle; legal when idle or in the done clock
//   is_read, a0,      cycle kind, a0 level and write data, captured at start
//   wdata
//   din               bus sample value, captured at the end of the last
//                     strobe clock on reads
//   done              high in the final (GAP) clock of the cycle
//   rdata             last byte sampled by a read cycle
//   cs_n, wr_n, rd_n, a0_o, dout, doe   bus pin drives
module ym_bus_phase
    import ym_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned STRB_CYC  = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       is_read,
    input  logic       a0,
    input  logic [7:0] wdata,
    input  logic [7:0] din,
    output logic       done,
    output logic [7:0] rdata,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a0_o,
    output logic [7:0] dout,
    output logic       doe
);

    localparam int unsigned MAX_CYC = max3(SETUP_CYC, STRB_CYC, HOLD_CYC);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    // Counter holds "clocks remaining in this phase minus one"; terminal at 0.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STRB_LD  = CNT_W'(STRB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    logic             active_q, active_d;
    phase_e           phase_q,  phase_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             rd_q,     rd_d;
    logic             a0_q,     a0_d;
    logic [7:0]       wdata_q,  wdata_d;
    logic [7:0]       rdata_q,  rdata_d;

    logic tc;
    logic on_bus;

    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        a0_d     = a0_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;

        tc   = (cnt_q == '0);
        done = active_q && (phase_q == GAP) && tc;

        if (active_q) begin
            if (!tc) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                unique case (phase_q)
                    SETUP: begin
                        phase_d = STRB;
                        cnt_d   = STRB_LD;
                    end
                    STRB: begin
                        phase_d = HOLD;
                        cnt_d   = HOLD_LD;
                        if (rd_q) begin
                            rdata_d = din;
                        end
                    end
                    HOLD: begin
                        phase_d = GAP;
                        cnt_d   = '0;
                    end
                    GAP: begin
                        active_d = 1'b0;
                    end
                    default: begin
                        active_d = 1'b0;
                    end
                endcase
            end
        end

        // A start in the done clock chains the next cycle with no extra idle.
        if (start) begin
            active_d = 1'b1;
            phase_d  = SETUP;
            cnt_d    = SETUP_LD;
            rd_d     = is_read;
            a0_d     = a0;
            wdata_d  = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            phase_q  <= SETUP;
            cnt_q    <= '0;
            rd_q     <= 1'b0;
            a0_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            a0_q     <= a0_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign on_bus = active_q && (phase_q != GAP);
    assign cs_n   = !on_bus;
    assign wr_n   = !(on_bus && (phase_q == STRB) && !rd_q);
    assign rd_n   = !(on_bus && (phase_q == STRB) &&  rd_q);
    assign a0_o   = a0_q;
    assign dout   = wdata_q;
    assign doe    = on_bus && !rd_q;
    assign rdata  = rdata_q;

endmodule

// File: rtl/ym_bus_master.sv
// ym_bus_master: host-side initiator for the YM2151 CPU bus.
//   Each accepted command polls the status busy flag, then writes the register
//   address (a0=0) and the register data (a0=1).
// Optional feature: define YM_BUS_TIMEOUT_EN to bound busy polling to TIMEOUT
//   polls; on expiry err is set (sticky until reset) and the write proceeds.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_addr, cmd_data           register address and data
//   ym_cs_n, ym_wr_n, ym_rd_n,   bus pins; ym_doe enables the top-level
//   ym_a0, ym_dout, ym_doe       tristate driver
//   ym_din                       bus sample value
//   status                       last status byte read
//   err                          sticky poll timeout flag
//
// state | meaning
// IDLE  | ready for a command
// POLL  | status read bus cycle in progress
// CHECK | one clock to inspect the busy bit
// ADDR  | address write bus cycle
// DATA  | data write bus cycle
module ym_bus_master
    import ym_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned STRB_CYC  = 2,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       ym_cs_n,
    output logic       ym_wr_n,
    output logic       ym_rd_n,
    output logic       ym_a0,
    output logic [7:0] ym_dout,
    output logic       ym_doe,
    input  logic [7:0] ym_din,
    output logic [7:0] status,
    output logic       err
);

    state_e     state_q, state_d;
    logic [7:0] addr_q,  addr_d;
    logic [7:0] data_q,  data_d;

    logic       ph_start;
    logic       ph_is_read;
    logic       ph_a0;
    logic [7:0] ph_wdata;
    logic       ph_done;
    logic [7:0] ph_rdata;

`ifdef YM_BUS_TIMEOUT_EN
    localparam int unsigned POLL_W = $clog2(TIMEOUT + 1);
    localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(TIMEOUT);

    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic              err_q,      err_d;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ph_start   = 1'b0;
        ph_is_read = 1'b0;
        ph_a0      = 1'b1;
        ph_wdata   = data_q;
`ifdef YM_BUS_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
        err_d      = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d     = cmd_addr;
                    data_d     = cmd_data;
                    state_d    = POLL;
                    ph_start   = 1'b1;
                    ph_is_read = 1'b1;
                    ph_a0      = 1'b1;
`ifdef YM_BUS_TIMEOUT_EN
                    poll_cnt_d = '0;
`endif
                end
            end
            POLL: begin
                if (ph_done) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Either branch launches a bus cycle that starts next clock.
                ph_start = 1'b1;
                ph_wdata = addr_q;
                if (ph_rdata[BUSY_BIT]) begin
`ifdef YM_BUS_TIMEOUT_EN
                    poll_cnt_d = poll_cnt_q + 1'b1;
                    if (poll_cnt_d >= POLL_MAX) begin
                        err_d      = 1'b1;
                        state_d    = ADDR;
                        ph_is_read = 1'b0;
                        ph_a0      = 1'b0;
                    end else begin
                        state_d    = POLL;
                        ph_is_read = 1'b1;
                        ph_a0      = 1'b1;
                    end
`else
                    state_d    = POLL;
                    ph_is_read = 1'b1;
                    ph_a0      = 1'b1;
`endif
                end else begin
                    state_d    = ADDR;
                    ph_is_read = 1'b0;
                    ph_a0      = 1'b0;
                end
            end
            ADDR: begin
                if (ph_done) begin
                    state_d    = DATA;
                    ph_start   = 1'b1;
                    ph_is_read = 1'b0;
                    ph_a0      = 1'b1;
                    ph_wdata   = data_q;
                end
            end
            DATA: begin
                if (ph_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

`ifdef YM_BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE);
    assign status    = ph_rdata;

    ym_bus_phase #(
        .SETUP_CYC (SETUP_CYC),
        .STRB_CYC  (STRB_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_phase (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (ph_start),
        .is_read (ph_is_read),
        .a0      (ph_a0),
        .wdata   (ph_wdata),
        .din     (ym_din),
        .done    (ph_done),
        .rdata   (ph_rdata),
        .cs_n    (ym_cs_n),
        .wr_n    (ym_wr_n),
        .rd_n    (ym_rd_n),
        .a0_o    (ym_a0),
        .dout    (ym_dout),
        .doe     (ym_doe)
    );

endmodule

// File: tb/tb_ym_bus_master.sv
// Bench for ym_bus_master: unit 0 uses default timing (TIMEOUT=4 when the
// timeout feature is built in), unit 1 uses SETUP=3, STRB=1, HOLD=2.
// Stimulus pushes the expected bus cycles of each command into a per-unit
// queue; a monitor per unit reconstructs every cs_n-low window and compares.
module tb_ym_bus_master;

    typedef struct packed {
        bit         is_wr;
        bit         a0;
        logic [7:0] data;
        int         cs_len;
        int         strb_len;
        int         strb_start;
    } exp_t;

    // Hand-derived timing per unit: {setup, strobe, hold}
    int setup_u [2] = '{1, 3};
    int strb_u  [2] = '{2, 1};
    int hold_u  [2] = '{1, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic [7:0] cmd_addr  [2];
    logic [7:0] cmd_data  [2];
    logic       cs_n      [2];
    logic       wr_n      [2];
    logic       rd_n      [2];
    logic       a0        [2];
    logic [7:0] dout      [2];
    logic       doe       [2];
    logic [7:0] din       [2];
    logic [7:0] status    [2];
    logic       err       [2];

    int checks = 0;
    int errors = 0;
    int busy_left  [2] = '{0, 0};
    bit busy_const [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    ym_bus_master #(.TIMEOUT(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]),
        .ym_cs_n(cs_n[0]), .ym_wr_n(wr_n[0]), .ym_rd_n(rd_n[0]),
        .ym_a0(a0[0]), .ym_dout(dout[0]), .ym_doe(doe[0]),
        .ym_din(din[0]), .status(status[0]), .err(err[0])
    );

    ym_bus_master #(.SETUP_CYC(3), .STRB_CYC(1), .HOLD_CYC(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_addr(cmd_addr[1]), .cmd_data(cmd_data[1]),
        .ym_cs_n(cs_n[1]), .ym_wr_n(wr_n[1]), .ym_rd_n(rd_n[1]),
        .ym_a0(a0[1]), .ym_dout(dout[1]), .ym_doe(doe[1]),
        .ym_din(din[1]), .status(status[1]), .err(err[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_mon
        exp_t       q[$];
        bit         in_win = 1'b0;
        int         cs_len, strb_len, strb_start;
        bit         wr_seen, rd_seen, stable;
        logic       a0_w, doe_w;
        logic [7:0] dout_w;
        exp_t       e;

        assign din[g] = (busy_const[g] || busy_left[g] > 0) ? 8'h80 : 8'h00;

        always @(negedge clk) begin
            if (!rst_n) begin
                in_win = 1'b0;
            end else begin
                if (!rd_n[g] && !wr_n[g]) begin
                    errors++;
                    $display("FAIL strobe_overlap u%0d: rd_n=0 wr_n=0, required never both low", g);
                end
                if (cs_n[g] && (!rd_n[g] || !wr_n[g])) begin
                    errors++;
                    $display("FAIL strobe_no_cs u%0d: strobe low with cs_n=1, required cs_n=0", g);
                end
                if (!cs_n[g]) begin
                    if (!in_win) begin
                        in_win = 1'b1;
                        cs_len = 0; strb_len = 0; strb_start = 0;
                        wr_seen = 1'b0; rd_seen = 1'b0; stable = 1'b1;
                        a0_w = a0[g]; doe_w = doe[g]; dout_w = dout[g];
                    end
                    cs_len++;
                    if (!wr_n[g] || !rd_n[g]) begin
                        strb_len++;
                        if (strb_start == 0) strb_start = cs_len;
                    end
                    if (!wr_n[g]) wr_seen = 1'b1;
                    if (!rd_n[g]) rd_seen = 1'b1;
                    if (a0[g] !== a0_w || doe[g] !== doe_w || dout[g] !== dout_w)
                        stable = 1'b0;
                end else if (in_win) begin
                    in_win = 1'b0;
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL bus_cycle u%0d: unexpected cycle wr=%0b a0=%0b d=%02h, required none",
                                 g, wr_seen, a0_w, dout_w);
                    end else begin
                        e = q.pop_front();
                        if (wr_seen != e.is_wr || rd_seen == e.is_wr || a0_w !== e.a0 ||
                            cs_len != e.cs_len || strb_len != e.strb_len ||
                            strb_start != e.strb_start || !stable ||
                            doe_w !== e.is_wr || (e.is_wr && dout_w !== e.data)) begin
                            errors++;
                            $display("FAIL bus_cycle u%0d: got wr=%0b rd=%0b a0=%0b d=%02h doe=%0b cs=%0d strb=%0d@%0d stable=%0b; required wr=%0b a0=%0b d=%02h doe=%0b cs=%0d strb=%0d@%0d stable=1",
                                     g, wr_seen, rd_seen, a0_w, dout_w, doe_w, cs_len, strb_len,
                                     strb_start, stable, e.is_wr, e.a0, e.data, e.is_wr,
                                     e.cs_len, e.strb_len, e.strb_start);
                        end
                    end
                    if (rd_seen && busy_left[g] > 0) busy_left[g]--;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_cyc(input int u, input bit is_wr, input bit a, input logic [7:0] d);
        exp_t e;
        e.is_wr      = is_wr;
        e.a0         = a;
        e.data       = d;
        e.cs_len     = setup_u[u] + strb_u[u] + hold_u[u];
        e.strb_len   = strb_u[u];
        e.strb_start = setup_u[u] + 1;
        if (u == 0) g_mon[0].q.push_back(e);
        else        g_mon[1].q.push_back(e);
    endtask

    task automatic push_cmd(input int u, input logic [7:0] a, input logic [7:0] d, input int polls);
        for (int i = 0; i < polls; i++) push_cyc(u, 1'b0, 1'b1, 8'h00);
        push_cyc(u, 1'b1, 1'b0, a);
        push_cyc(u, 1'b1, 1'b1, d);
    endtask

    function automatic int exp_lat(input int u, input int polls);
        int cyc;
        cyc = setup_u[u] + strb_u[u] + hold_u[u] + 1;
        return 3 * cyc + 1 + (polls - 1) * (cyc + 1);
    endfunction

    task automatic wait_ready(input int u);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready[u] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready[u]) begin
            errors++;
            $display("FAIL ready_timeout u%0d: cmd_ready=0 after 500 clocks, required 1", u);
        end
    endtask

    // Counts clocks from the handshake edge until cmd_ready is high again.
    task automatic wait_idle(input int u, input int req, input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!cmd_ready[u] && n < 500);
        chk(name, n, req);
    endtask

    task automatic issue(input int u, input logic [7:0] a, input logic [7:0] d,
                         input int polls, input string name);
        wait_ready(u);
        push_cmd(u, a, d, polls);
        cmd_addr[u]  = a;
        cmd_data[u]  = d;
        cmd_valid[u] = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid[u] = 1'b0;
        cmd_addr[u]  = 8'hFF;
        cmd_data[u]  = 8'hFF;
        chk({name, "_ready_drop"}, cmd_ready[u], 0);
        wait_idle(u, exp_lat(u, polls), {name, "_latency"});
    endtask

    task automatic chk_reset(input int u, input string name);
        chk(name, {cmd_ready[u], cs_n[u], wr_n[u], rd_n[u], a0[u], dout[u], doe[u], status[u], err[u]},
            {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
    endtask

    initial begin
        int n;
        for (int u = 0; u < 2; u++) begin
            cmd_valid[u] = 1'b0;
            cmd_addr[u]  = 8'h00;
            cmd_data[u]  = 8'h00;
        end
        #2;
        chk_reset(0, "reset_u0");
        chk_reset(1, "reset_u1");
        #20;
        rst_n = 1'b1;

        // Basic write, busy clear
        issue(0, 8'h08, 8'h78, 1, "basic");
        chk("basic_status", status[0], 8'h00);

        // Busy for three reads
        busy_left[0] = 3;
        issue(0, 8'h10, 8'h3C, 4, "busy3");
        chk("busy3_status", status[0], 8'h00);

        // Back-to-back with cmd_valid held high
        wait_ready(0);
        push_cmd(0, 8'h20, 8'hC7, 1);
        push_cmd(0, 8'h28, 8'h4A, 1);
        cmd_addr[0] = 8'h20; cmd_data[0] = 8'hC7; cmd_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        cmd_addr[0] = 8'h28; cmd_data[0] = 8'h4A;
        chk("b2b_first_ready_drop", cmd_ready[0], 0);
        wait_idle(0, 16, "b2b_first_latency");
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        chk("b2b_second_accepted", cmd_ready[0], 0);
        wait_idle(0, 16, "b2b_second_latency");

        // Reset in the address write strobe
        wait_ready(0);
        push_cyc(0, 1'b0, 1'b1, 8'h00);
        cmd_addr[0] = 8'h30; cmd_data[0] = 8'h55; cmd_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        n = 0;
        while (!(wr_n[0] === 1'b0 && a0[0] === 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_addr_strobe", {wr_n[0], a0[0]}, 2'b00);
        #2;
        rst_n = 1'b0;
        g_mon[0].q.delete();
        #1;
        chk_reset(0, "rst_mid_outputs");
        #20;
        rst_n = 1'b1;
        issue(0, 8'h38, 8'hA5, 1, "after_rst");

`ifdef YM_BUS_TIMEOUT_EN
        busy_const[0] = 1'b1;
        issue(0, 8'h40, 8'h11, 4, "timeout");
        chk("timeout_err", err[0], 1);
        chk("timeout_status", status[0], 8'h80);
        busy_const[0] = 1'b0;
        issue(0, 8'h41, 8'h22, 1, "post_timeout");
        chk("post_timeout_err_sticky", err[0], 1);
`else
        chk("err_tied_low", err[0], 0);
`endif

        // Non-default timing unit
        busy_left[1] = 1;
        issue(1, 8'h60, 8'h9E, 2, "slow");
        chk("slow_status", status[1], 8'h00);
        issue(1, 8'h61, 8'h01, 1, "slow2");

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty_u0", g_mon[0].q.size(), 0);
        chk("queue_empty_u1", g_mon[1].q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
